fir_engine_ctrl: RTL and testbench

Sequencer for the FIR datapath: accepts one AXI-Stream input sample at a time and writes it into the data BRAM, which is used as a circular buffer. It then sweeps the tap BRAM and data BRAM for Tape_Num taps, accumulates the products, and emits one output sample on AXI-Stream. It sits between the AXI-Lite config block (which provides ap_start and owns tap RAM writes while idle) and the two BRAMs.

---
 rtl/fir_pkg.sv | 12 +
 rtl/fir_mac_unit.sv | 32 +++
 rtl/fir_engine_ctrl.sv | 143 ++++++++++++++
 tb/tb_fir_engine_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and address helpers for the FIR engine.
package fir_pkg;

    typedef enum logic [2:0] {IDLE, CLR, WAIT_IN, MAC, OUT, DONE} state_e;

    localparam int ADDR_SHIFT = 2;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: multiply-accumulate fed by BRAM outputs; en marks an issued read, product lands a cycle later.
module fir_mac_unit #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] acc_o
);

    logic         vld_q;
    logic [W-1:0] acc_q, acc_d, prod;

    // Low W bits of a product are the same for signed and unsigned operands.
    assign prod  = a_i * b_i;
    assign acc_d = clr_i ? '0 : vld_q ? acc_q + prod : acc_q;
    assign acc_o = acc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= 1'b0;
            acc_q <= '0;
        end else begin
            vld_q <= en_i;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fir_engine_ctrl.sv
// fir_engine_ctrl: FIR sequencer; writes each input into a circular data BRAM,
// sweeps tap/data BRAMs, accumulates and emits one output per input.
module fir_engine_ctrl
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ap_start,
    output logic                   ap_idle,
    output logic                   ap_done,
    output logic                   engine_busy,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic                   ss_tlast,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic                   sm_tlast,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic [pDATA_WIDTH-1:0] data_Di,
    input  logic [pDATA_WIDTH-1:0] data_Do
);

    localparam int PW = ptr_w(Tape_Num);
    localparam int KW = ptr_w(Tape_Num + 1);

    state_e                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d, rd_idx;
    logic [PW-1:0]          head_q, head_d;
    logic                   last_q, last_d;
    logic                   accept, issue;
    logic [pDATA_WIDTH-1:0] acc;

    assign accept      = (state_q == WAIT_IN) && ss_tvalid;
    assign issue       = (state_q == MAC) && (k_q < KW'(Tape_Num));
    assign ap_idle     = state_q == IDLE;
    assign engine_busy = !ap_idle;
    // (head - k) mod Tape_Num; the modular sum stays correct even if head + Tape_Num overflows KW.
    assign rd_idx = (KW'(head_q) >= k_q) ? KW'(head_q) - k_q : KW'(head_q) + KW'(Tape_Num) - k_q;

    fir_mac_unit #(.W(pDATA_WIDTH)) u_mac (
        .clk_i (axis_clk),
        .rst_ni(axis_rst_n),
        .clr_i (accept),
        .en_i  (issue),
        .a_i   (tap_Do),
        .b_i   (data_Do),
        .acc_o (acc)
    );

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            head_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            head_q  <= head_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        head_d    = head_q;
        last_d    = last_q;
        ap_done   = 1'b0;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        sm_tlast  = 1'b0;
        sm_tdata  = '0;
        tap_EN    = 1'b0;
        tap_A     = '0;
        data_EN   = 1'b0;
        data_WE   = 4'h0;
        data_A    = '0;
        data_Di   = '0;
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d = CLR;
                    k_d     = '0;
                end
            end
            CLR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = pADDR_WIDTH'(k_q) << ADDR_SHIFT;
                k_d     = k_q + 1'b1;
                state_d = (k_q == KW'(Tape_Num - 1)) ? WAIT_IN : CLR;
            end
            WAIT_IN: begin
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    data_EN = 1'b1;
                    data_WE = 4'hF;
                    data_A  = pADDR_WIDTH'(head_q) << ADDR_SHIFT;
                    data_Di = ss_tdata;
                    last_d  = ss_tlast;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                tap_EN  = issue;
                data_EN = issue;
                tap_A   = issue ? pADDR_WIDTH'(k_q) << ADDR_SHIFT : '0;
                data_A  = issue ? pADDR_WIDTH'(rd_idx) << ADDR_SHIFT : '0;
                k_d     = k_q + 1'b1;
                // Extra cycle lets the final product arrive from the BRAMs.
                state_d = (k_q == KW'(Tape_Num)) ? OUT : MAC;
            end
            OUT: begin
                sm_tvalid = 1'b1;
                sm_tdata  = acc;
                sm_tlast  = last_q;
                if (sm_tready) begin
                    head_d  = (head_q == PW'(Tape_Num - 1)) ? '0 : head_q + 1'b1;
                    state_d = last_q ? DONE : WAIT_IN;
                end
            end
            DONE: begin
                ap_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fir_engine_ctrl.sv
// tb_fir_engine_ctrl: drives fir_engine_ctrl with BRAM models and checks outputs against a sliding-window FIR model.
module tb_fir_engine_ctrl;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int N  = 11;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic          ap_idle, ap_done, engine_busy;
    logic [DW-1:0] ss_tdata = '0;
    logic          ss_tvalid = 1'b0;
    logic          ss_tready;
    logic          ss_tlast = 1'b0;
    logic [DW-1:0] sm_tdata;
    logic          sm_tvalid;
    logic          sm_tready = 1'b0;
    logic          sm_tlast;
    logic          tap_EN, data_EN;
    logic [AW-1:0] tap_A, data_A;
    logic [3:0]    data_WE;
    logic [DW-1:0] tap_Do, data_Di, data_Do;

    logic [DW-1:0] tap_mem  [1024];
    logic [DW-1:0] data_mem [1024];
    logic [DW-1:0] hist     [N];

    int n_cmp = 0;
    int n_err = 0;

    fir_engine_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(N)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .ap_start   (ap_start),
        .ap_idle    (ap_idle),
        .ap_done    (ap_done),
        .engine_busy(engine_busy),
        .ss_tdata   (ss_tdata),
        .ss_tvalid  (ss_tvalid),
        .ss_tready  (ss_tready),
        .ss_tlast   (ss_tlast),
        .sm_tdata   (sm_tdata),
        .sm_tvalid  (sm_tvalid),
        .sm_tready  (sm_tready),
        .sm_tlast   (sm_tlast),
        .tap_EN     (tap_EN),
        .tap_A      (tap_A),
        .tap_Do     (tap_Do),
        .data_EN    (data_EN),
        .data_WE    (data_WE),
        .data_A     (data_A),
        .data_Di    (data_Di),
        .data_Do    (data_Do)
    );

    always #5 axis_clk = ~axis_clk;

    // Single-port BRAMs with one-cycle read latency.
    always @(posedge axis_clk) begin
        if (tap_EN) tap_Do <= tap_mem[tap_A[AW-1:2]];
        if (data_EN) begin
            if (data_WE == 4'hF) data_mem[data_A[AW-1:2]] <= data_Di;
            data_Do <= data_mem[data_A[AW-1:2]];
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // y[n] = sum_k h[k] * x[n-k], history zeroed at run start, wrapping mod 2^32.
    function automatic logic [DW-1:0] model_push(input logic [DW-1:0] x);
        logic [DW-1:0] s = '0;
        for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        for (int k = 0; k < N; k++) s += tap_mem[k] * hist[k];
        return s;
    endfunction

    task automatic start_run();
        for (int k = 0; k < N; k++) hist[k] = '0;
        ap_start = 1'b1;
        @(negedge axis_clk);
        ap_start = 1'b0;
        chk("busy_on_start", {31'b0, engine_busy}, 1);
        chk("clr_we", {28'b0, data_WE}, 4'hF);
    endtask

    task automatic send(input logic [DW-1:0] x, input logic last, input int stall, input logic poke);
        int n;
        logic [DW-1:0] exp;
        exp = model_push(x);
        ss_tdata = x;
        ss_tlast = last;
        ss_tvalid = 1'b1;
        n = 0;
        while (!ss_tready && n < 100) begin
            @(negedge axis_clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 100), 1);
        @(negedge axis_clk);
        ss_tvalid = 1'b0;
        ss_tlast = 1'b0;
        n = 1;
        while (!sm_tvalid && n < 100) begin
            @(negedge axis_clk);
            n++;
        end
        chk("latency", 32'(n), 32'(N + 2));
        for (int i = 0; i < stall; i++) begin
            chk("stall_data", sm_tdata, exp);
            chk("stall_last", {31'b0, sm_tlast}, {31'b0, last});
            chk("stall_ss_tready", {31'b0, ss_tready}, 0);
            if (poke && i == stall / 2) ap_start = 1'b1;
            @(negedge axis_clk);
            ap_start = 1'b0;
        end
        chk("out_valid", {31'b0, sm_tvalid}, 1);
        chk("out_data", sm_tdata, exp);
        chk("out_last", {31'b0, sm_tlast}, {31'b0, last});
        sm_tready = 1'b1;
        @(negedge axis_clk);
        sm_tready = 1'b0;
        chk("done_pulse", {31'b0, ap_done}, {31'b0, last});
        if (last) begin
            @(negedge axis_clk);
            chk("done_clear", {31'b0, ap_done}, 0);
            chk("idle_after", {31'b0, ap_idle}, 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_idle"}, {31'b0, ap_idle}, 1);
        chk({tag, "_done"}, {31'b0, ap_done}, 0);
        chk({tag, "_busy"}, {31'b0, engine_busy}, 0);
        chk({tag, "_ss_tready"}, {31'b0, ss_tready}, 0);
        chk({tag, "_sm_tvalid"}, {31'b0, sm_tvalid}, 0);
        chk({tag, "_sm_tlast"}, {31'b0, sm_tlast}, 0);
        chk({tag, "_sm_tdata"}, sm_tdata, 0);
        chk({tag, "_en"}, {30'b0, tap_EN, data_EN}, 0);
        chk({tag, "_we"}, {28'b0, data_WE}, 0);
        chk({tag, "_addr"}, {8'b0, tap_A, data_A}, 0);
        chk({tag, "_di"}, data_Di, 0);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 1024; i++) begin
            tap_mem[i] = '0;
            data_mem[i] = $urandom;
        end
        repeat (3) @(negedge axis_clk);
        check_reset_outputs("rst");
        axis_rst_n = 1'b1;
        @(negedge axis_clk);

        // Identity taps.
        tap_mem[0] = 1;
        start_run();
        send(5, 0, 0, 0);
        send(DW'(-3), 0, 0, 0);
        send(7, 1, 0, 0);

        // All-ones taps, window sums across the circular-buffer wrap.
        for (int k = 0; k < N; k++) tap_mem[k] = 1;
        start_run();
        for (int i = 1; i <= 13; i++) send(DW'(i), i == 13, 0, 0);

        // Taps 1..11, single flagged input.
        for (int k = 0; k < N; k++) tap_mem[k] = DW'(k + 1);
        start_run();
        send(2, 1, 0, 0);

        // Backpressure with a stray ap_start pulse while stalled.
        start_run();
        send(3, 0, 20, 1);
        send(4, 0, 0, 0);
        send(DW'(-1), 1, 5, 1);

        // Product truncation / accumulator wrap.
        for (int k = 0; k < N; k++) tap_mem[k] = '0;
        tap_mem[0] = 32'h7FFF_FFFF;
        start_run();
        send(2, 1, 0, 0);

        // Random taps, samples and stalls.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) tap_mem[k] = (r == 0) ? DW'($urandom_range(0, 15)) : $urandom;
            start_run();
            cnt = $urandom_range(5, 15);
            for (int i = 0; i < cnt; i++) send($urandom, i == cnt - 1, $urandom_range(0, 3), 0);
        end

        // Reset during MAC, then a fresh run must see zeroed history.
        start_run();
        ss_tdata = 32'h1234_5678;
        ss_tvalid = 1'b1;
        cnt = 0;
        while (!ss_tready && cnt < 100) begin
            @(negedge axis_clk);
            cnt++;
        end
        @(negedge axis_clk);
        ss_tvalid = 1'b0;
        repeat (4) @(negedge axis_clk);
        chk("mac_active", {31'b0, tap_EN}, 1);
        axis_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        start_run();
        for (int i = 0; i < 4; i++) send($urandom, i == 3, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
